pipeline_hazard_forward_unit: RTL and testbench

- Scoreboard-based hazard and forwarding controller for the 5-stage 20-bit pipeline; successor to the fixed stall-only hazard detector.
- Tracks in-flight register writes in three slots: ID/EX, EX/MEM and MEM/WB.
- Generates the IF/ID stall, jump flush and registered forwarding selects for the EX operand muxes.
- Parametrised in register-address width, flush depth and zero-register handling; includes a saturating stall counter.

---
 rtl/pipeline_hazard_forward_unit_if.sv | 38 +++
 rtl/pipeline_hazard_forward_unit.sv | 127 ++++++++++++
 tb/tb_pipeline_hazard_forward_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_forward_unit_if.sv
// Purpose : ID-stage issue bus and EX-stage hazard/forwarding results for
//           pipeline_hazard_forward_unit.
// Signals : ID_Valid, ID_SrcA/B, ID_UsesA/B, ID_Dest, ID_WritesReg, ID_IsLoad,
//           JumpEnable (issuer -> unit); Stall, IF_ID_Flush (combinational),
//           EX_Valid, EX_FwdSelA/B, StallCount (registered) (unit -> pipeline).
// Modports: master = pipeline/issuer side, slave = hazard unit.
interface pipeline_hazard_forward_unit_if #(
  parameter int unsigned REG_AW = 4,
  parameter int unsigned CNT_W  = 16
);
  logic              ID_Valid;
  logic [REG_AW-1:0] ID_SrcA;
  logic [REG_AW-1:0] ID_SrcB;
  logic              ID_UsesA;
  logic              ID_UsesB;
  logic [REG_AW-1:0] ID_Dest;
  logic              ID_WritesReg;
  logic              ID_IsLoad;
  logic              JumpEnable;
  logic              Stall;
  logic              IF_ID_Flush;
  logic              EX_Valid;
  logic [1:0]        EX_FwdSelA;
  logic [1:0]        EX_FwdSelB;
  logic [CNT_W-1:0]  StallCount;

  modport master (
    output ID_Valid, ID_SrcA, ID_SrcB, ID_UsesA, ID_UsesB, ID_Dest,
           ID_WritesReg, ID_IsLoad, JumpEnable,
    input  Stall, IF_ID_Flush, EX_Valid, EX_FwdSelA, EX_FwdSelB, StallCount
  );

  modport slave (
    input  ID_Valid, ID_SrcA, ID_SrcB, ID_UsesA, ID_UsesB, ID_Dest,
           ID_WritesReg, ID_IsLoad, JumpEnable,
    output Stall, IF_ID_Flush, EX_Valid, EX_FwdSelA, EX_FwdSelB, StallCount
  );
endinterface

// File: rtl/pipeline_hazard_forward_unit.sv
// Purpose : Scoreboard hazard/forwarding controller for the 5-stage pipeline.
//           Three slots (ID/EX, EX/MEM, MEM/WB) track in-flight register
//           writes; the unit produces the IF/ID stall, the jump flush and the
//           registered EX operand forwarding selects.
// Ports   : Clock  - rising-edge clock
//           Reset  - synchronous, active-low reset
//           bus    - pipeline_hazard_forward_unit_if.slave (ID issue fields in,
//                    Stall/IF_ID_Flush/EX_Valid/EX_FwdSelA/B/StallCount out)
// Config  : FORWARDING_EN defined   -> forwarding, only load-use stalls
//           FORWARDING_EN undefined -> no forwarding, stall on any match
// FwdSel  : 00 RF, 01 EX/MEM, 10 MEM/WB, 11 WB bypass register
module pipeline_hazard_forward_unit #(
  parameter int unsigned REG_AW   = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned FLUSH_EX = 0
) (
  input  logic                          Clock,
  input  logic                          Reset,
  pipeline_hazard_forward_unit_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              writes;
    logic              is_load;
  } slot_t;

  slot_t            r_slot [3];
  logic             r_ex_valid;
  logic [1:0]       r_fwd_a;
  logic [1:0]       r_fwd_b;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [2:0]       w_match_a;
  logic [2:0]       w_match_b;
  logic             w_hazard;
  logic             w_stall;
  logic             w_issue;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;
  logic             w_unused_slot2_load;

  // A slot matches a source only for a real, reading ID instruction.
  function automatic logic f_match(slot_t s, logic [REG_AW-1:0] src,
                                   logic uses, logic id_valid);
    logic zero_src;
    zero_src = (ZERO_REG != 0) && (src == '0);
    return id_valid && uses && s.valid && s.writes && (s.dest == src) && !zero_src;
  endfunction

`ifdef FORWARDING_EN
  // Youngest producer wins.
  function automatic logic [1:0] f_sel(logic [2:0] m);
    if (m[0])      return 2'b01;
    else if (m[1]) return 2'b10;
    else if (m[2]) return 2'b11;
    else           return 2'b00;
  endfunction
`endif

  // Source-vs-slot match vectors.
  always_comb begin
    w_match_a = '0;
    w_match_b = '0;
    for (int i = 0; i < 3; i++) begin
      w_match_a[i] = f_match(r_slot[i], bus.ID_SrcA, bus.ID_UsesA, bus.ID_Valid);
      w_match_b[i] = f_match(r_slot[i], bus.ID_SrcB, bus.ID_UsesB, bus.ID_Valid);
    end
  end

  // Hazard, stall/issue decision and next forwarding selects.
  always_comb begin
    w_hazard = 1'b0;
    w_fwd_a  = 2'b00;
    w_fwd_b  = 2'b00;
`ifdef FORWARDING_EN
    w_hazard = r_slot[0].is_load & (w_match_a[0] | w_match_b[0]);
`else
    w_hazard = |(w_match_a | w_match_b);
`endif
    // Flush beats hazard: a jump discards the ID instruction instead of holding it.
    w_stall = w_hazard & ~bus.JumpEnable & Reset;
    w_issue = bus.ID_Valid & ~w_stall & ~bus.JumpEnable;
`ifdef FORWARDING_EN
    if (w_issue) begin
      w_fwd_a = f_sel(w_match_a);
      w_fwd_b = f_sel(w_match_b);
    end
`endif
  end

  // Slot shift register, EX-aligned selects and saturating stall counter.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int i = 0; i < 3; i++) r_slot[i] <= '0;
      r_ex_valid  <= 1'b0;
      r_fwd_a     <= 2'b00;
      r_fwd_b     <= 2'b00;
      r_stall_cnt <= '0;
    end else begin
      r_slot[2] <= r_slot[1];
      r_slot[1] <= r_slot[0];
      if (bus.JumpEnable && (FLUSH_EX != 0)) r_slot[1].valid <= 1'b0;
      r_slot[0] <= '{valid:   w_issue,
                     dest:    bus.ID_Dest,
                     writes:  bus.ID_WritesReg,
                     is_load: bus.ID_IsLoad};
      r_ex_valid <= w_issue;
      r_fwd_a    <= w_fwd_a;
      r_fwd_b    <= w_fwd_b;
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // The oldest slot's load flag has no consumer.
  assign w_unused_slot2_load = r_slot[2].is_load;

  assign bus.Stall       = w_stall;
  assign bus.IF_ID_Flush = bus.JumpEnable & Reset;
  assign bus.EX_Valid    = r_ex_valid;
  assign bus.EX_FwdSelA  = r_fwd_a;
  assign bus.EX_FwdSelB  = r_fwd_b;
  assign bus.StallCount  = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_forward_unit.sv
// Directed bench for pipeline_hazard_forward_unit. Two instances share one
// stimulus stream: u0 (ZERO_REG=0, FLUSH_EX=0, CNT_W=16) and
// u1 (ZERO_REG=1, FLUSH_EX=1, CNT_W=2). Expectations follow FORWARDING_EN.
module tb_pipeline_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid, id_ua, id_ub, id_wr, id_ld, jmp;
  logic [3:0] id_sa, id_sb, id_d;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  pipeline_hazard_forward_unit_if #(.REG_AW(4), .CNT_W(16)) if0 ();
  pipeline_hazard_forward_unit_if #(.REG_AW(4), .CNT_W(2))  if1 ();

  assign if0.ID_Valid = id_valid;  assign if1.ID_Valid = id_valid;
  assign if0.ID_SrcA = id_sa;      assign if1.ID_SrcA = id_sa;
  assign if0.ID_SrcB = id_sb;      assign if1.ID_SrcB = id_sb;
  assign if0.ID_UsesA = id_ua;     assign if1.ID_UsesA = id_ua;
  assign if0.ID_UsesB = id_ub;     assign if1.ID_UsesB = id_ub;
  assign if0.ID_Dest = id_d;       assign if1.ID_Dest = id_d;
  assign if0.ID_WritesReg = id_wr; assign if1.ID_WritesReg = id_wr;
  assign if0.ID_IsLoad = id_ld;    assign if1.ID_IsLoad = id_ld;
  assign if0.JumpEnable = jmp;     assign if1.JumpEnable = jmp;

  pipeline_hazard_forward_unit #(.REG_AW(4), .CNT_W(16), .ZERO_REG(0), .FLUSH_EX(0))
    u0 (.Clock(clk), .Reset(rst), .bus(if0));
  pipeline_hazard_forward_unit #(.REG_AW(4), .CNT_W(2), .ZERO_REG(1), .FLUSH_EX(1))
    u1 (.Clock(clk), .Reset(rst), .bus(if1));

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int v, input int sa, input int ua, input int sb, input int ub,
                       input int d, input int w, input int ld, input int j);
    id_valid = 1'(v); id_sa = 4'(sa); id_ua = 1'(ua); id_sb = 4'(sb); id_ub = 1'(ub);
    id_d = 4'(d); id_wr = 1'(w); id_ld = 1'(ld); jmp = 1'(j);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_drain();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  // Producer, `gap` independent instructions, then a dependent consumer.
  task automatic run_dep(input bit load, input int gap, input bit bsame,
                         input int exp_stall, input int exp_a, input int exp_b);
    int p;
    int n;
    p = load ? 2 : 3;
    drive(1, 1, 1, 2, load ? 0 : 1, p, 1, load ? 1 : 0, 0);
    check("prod_stall", 32'(if0.Stall), 0);
    tick();
    check("prod_exv", 32'(if0.EX_Valid), 1);
    for (int g = 0; g < gap; g++) begin
      drive(1, 8, 1, 9, 1, 7, 1, 0, 0);
      tick();
    end
    drive(1, p, 1, bsame ? p : 4, 1, load ? 6 : 5, 1, 0, 0);
    n = 0;
    while (if0.Stall && n < 8) begin
      n++;
      check("stall_u1", 32'(if1.Stall), 1);
      tick();
      check("bubble_exv", 32'(if0.EX_Valid), 0);
    end
    check("stall_cycles", 32'(n), 32'(exp_stall));
    tick();
    check("cons_exv0", 32'(if0.EX_Valid), 1);
    check("cons_selA0", 32'(if0.EX_FwdSelA), 32'(exp_a));
    check("cons_selB0", 32'(if0.EX_FwdSelB), 32'(exp_b));
    check("cons_selA1", 32'(if1.EX_FwdSelA), 32'(exp_a));
    check("cons_selB1", 32'(if1.EX_FwdSelB), 32'(exp_b));
    idle_drain();
  endtask

  initial begin
    // Reset held with a busy, jumping ID stage.
    rst = 1'b0;
    drive(1, 3, 1, 3, 1, 3, 1, 1, 1);
    check("rst_stall", 32'(if0.Stall), 0);
    check("rst_flush", 32'(if0.IF_ID_Flush), 0);
    repeat (2) tick();
    check("rst_exv0", 32'(if0.EX_Valid), 0);
    check("rst_selA0", 32'(if0.EX_FwdSelA), 0);
    check("rst_selB0", 32'(if0.EX_FwdSelB), 0);
    check("rst_cnt0", 32'(if0.StallCount), 0);
    check("rst_cnt1", 32'(if1.StallCount), 0);
    check("rst_exv1", 32'(if1.EX_Valid), 0);
    rst = 1'b1;
    drive(1, 1, 1, 2, 1, 7, 1, 0, 0);
    tick();
    check("post_rst_exv", 32'(if0.EX_Valid), 1);
    check("post_rst_sel", 32'(if0.EX_FwdSelA), 0);
    idle_drain();

    // Dependencies at distance 1, 2, 3 and load-use.
    if (FWD) begin
      run_dep(0, 0, 0, 0, 1, 0);
      run_dep(0, 1, 0, 0, 2, 0);
      run_dep(0, 2, 0, 0, 3, 0);
      run_dep(1, 0, 1, 1, 2, 2);
    end else begin
      run_dep(0, 0, 0, 3, 0, 0);
      run_dep(0, 1, 0, 2, 0, 0);
      run_dep(0, 2, 0, 1, 0, 0);
      run_dep(1, 0, 1, 3, 0, 0);
    end
    check("cnt0_a", 32'(if0.StallCount), FWD ? 1 : 9);
    check("cnt1_a", 32'(if1.StallCount), FWD ? 1 : 3);

    // Jump during a load-use stall; u1 also kills the load.
    drive(1, 1, 1, 2, 0, 2, 1, 1, 0);
    tick();
    drive(1, 2, 1, 2, 1, 6, 1, 0, 1);
    check("jmp_stall0", 32'(if0.Stall), 0);
    check("jmp_stall1", 32'(if1.Stall), 0);
    check("jmp_flush0", 32'(if0.IF_ID_Flush), 1);
    check("jmp_flush1", 32'(if1.IF_ID_Flush), 1);
    tick();
    check("jmp_exv0", 32'(if0.EX_Valid), 0);
    check("jmp_exv1", 32'(if1.EX_Valid), 0);
    check("jmp_cnt0", 32'(if0.StallCount), FWD ? 1 : 9);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 2, 1, 2, 1, 6, 1, 0, 0);
    check("late_stall0", 32'(if0.Stall), FWD ? 0 : 1);
    check("late_stall1", 32'(if1.Stall), 0);
    tick();
    check("late_exv0", 32'(if0.EX_Valid), FWD ? 1 : 0);
    check("late_selA0", 32'(if0.EX_FwdSelA), FWD ? 3 : 0);
    check("late_selB0", 32'(if0.EX_FwdSelB), FWD ? 3 : 0);
    check("late_exv1", 32'(if1.EX_Valid), 1);
    check("late_selA1", 32'(if1.EX_FwdSelA), 0);
    check("late_selB1", 32'(if1.EX_FwdSelB), 0);
    idle_drain();

    // Register 0 writer then reader.
    drive(1, 1, 1, 2, 1, 0, 1, 0, 0);
    tick();
    drive(1, 0, 1, 4, 1, 5, 1, 0, 0);
    check("zr_stall0", 32'(if0.Stall), FWD ? 0 : 1);
    check("zr_stall1", 32'(if1.Stall), 0);
    tick();
    check("zr_exv0", 32'(if0.EX_Valid), FWD ? 1 : 0);
    check("zr_selA0", 32'(if0.EX_FwdSelA), FWD ? 1 : 0);
    check("zr_exv1", 32'(if1.EX_Valid), 1);
    check("zr_selA1", 32'(if1.EX_FwdSelA), 0);
    check("zr_selB1", 32'(if1.EX_FwdSelB), 0);
    idle_drain();
    check("cnt0_b", 32'(if0.StallCount), FWD ? 1 : 11);
    check("cnt1_b", 32'(if1.StallCount), FWD ? 1 : 3);

    // Reset asserted in the middle of a load-use stall.
    drive(1, 1, 1, 2, 0, 2, 1, 1, 0);
    tick();
    drive(1, 2, 1, 2, 1, 6, 1, 0, 0);
    check("mid_stall0", 32'(if0.Stall), 1);
    check("mid_stall1", 32'(if1.Stall), 1);
    rst = 1'b0;
    #1;
    check("mid_rst_stall0", 32'(if0.Stall), 0);
    check("mid_rst_stall1", 32'(if1.Stall), 0);
    tick();
    check("mid_rst_cnt0", 32'(if0.StallCount), 0);
    check("mid_rst_cnt1", 32'(if1.StallCount), 0);
    check("mid_rst_exv0", 32'(if0.EX_Valid), 0);
    drive(1, 2, 1, 2, 1, 6, 1, 0, 1);
    check("mid_rst_flush", 32'(if0.IF_ID_Flush), 0);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
